// File: rtl/kgp_risc_pkg.sv
// Shared types for the KGP RISC core back end.
//   wr_sel_e   : register-file write target code (none / r31 / reg1Addr / reg2Addr)
//   src_e      : where a result's data comes from (ALU now, or load data later)
//   wb_state_e : writeback sequencer states
//   wb_entry_t : one writeback queue entry {sel, src, data}
package kgp_risc_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_RA   = 2'b01,
    WR_REG1 = 2'b10,
    WR_REG2 = 2'b11
  } wr_sel_e;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    ISSUE    = 2'b01,
    WAIT_MEM = 2'b10
  } wb_state_e;

  typedef struct packed {
    wr_sel_e     sel;
    src_e        src;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue storage: circular buffer of wb_entry_t with occupancy count.
//   clk, rst   : clock, asynchronous active-low reset (clears pointers/count)
//   push/wdata : write one entry (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   head       : entry at the read pointer, valid when !empty
//   full/empty : occupancy flags; count : entries held (0..DEPTH)
module wb_fifo
  import kgp_risc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              wdata,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: queues execute results and retires them in order to the
// register file, waiting for load data from memory where needed.
//   clk, rst              : clock, asynchronous active-low reset
//   res_valid/res_ready   : result handshake from execute (res_ready = !full)
//   res_sel/res_src/res_data : write target, data source, ALU data
//   mem_rvalid/mem_rdata  : load data return
//   writeReg/writeData    : registered register-file write (writeReg=00 -> no write)
//   stall                 : queue full or head waiting on load data
//   err                   : sticky; bit0 spurious mem_rvalid, bit1 load timeout
// Build option: define WB_LOAD_TIMEOUT_EN to retire a load head with no write
// after TIMEOUT cycles in WAIT_MEM without data; otherwise loads wait forever.
module writeback_unit
  import kgp_risc_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [1:0]  res_sel,
  input  logic        res_src,
  input  logic [31:0] res_data,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  writeReg,
  output logic [31:0] writeData,
  output logic        stall,
  output logic [1:0]  err
);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("writeback_unit: DEPTH must be a power of two in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("writeback_unit: TIMEOUT must be in 1..255");
  end

  wb_state_e             state_q, state_d;
  wr_sel_e               wr_sel_q, wr_sel_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [1:0]            err_q, err_d;

  wb_entry_t             in_ent, head;
  logic                  full, empty;
  logic [$clog2(DEPTH):0] count;
  logic                  push, pop;
  logic                  head_vld, head_is_load, rv_take, spurious, tmo_pop;

  assign in_ent    = '{sel: wr_sel_e'(res_sel), src: src_e'(res_src), data: res_data};
  assign res_ready = rst & ~full;
  assign push      = res_valid & res_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_ent),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State is EMPTY exactly when the queue holds nothing, so the head entry is
  // meaningful in every other state.
  assign head_vld     = (state_q != EMPTY);
  assign head_is_load = head_vld & (head.src == SRC_LOAD);
  // Load data is taken as soon as a load is at the head, even on the ISSUE
  // cycle before the move to WAIT_MEM; only data with no load to match is spurious.
  assign rv_take      = mem_rvalid & head_is_load;
  assign spurious     = mem_rvalid & ~head_is_load;

`ifdef WB_LOAD_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  assign tmo_pop = (state_q == WAIT_MEM) & ~mem_rvalid & (tmo_q == 8'(TIMEOUT - 1));
`else
  assign tmo_pop = 1'b0;
`endif

  assign pop = head_vld & ((head.src == SRC_ALU) | rv_take | tmo_pop);

  always_comb begin
    state_d   = state_q;
    wr_sel_d  = WR_NONE;
    wr_data_d = wr_data_q;
    err_d     = err_q | {tmo_pop, spurious};

    // A timed-out load retires silently: no write, data bus held.
    if (pop && !tmo_pop) begin
      wr_sel_d  = head.sel;
      wr_data_d = (head.src == SRC_ALU) ? head.data : mem_rdata;
    end

    case (state_q)
      EMPTY: if (push) state_d = ISSUE;
      ISSUE, WAIT_MEM: begin
        if (pop && !push && count == 1) state_d = EMPTY;
        else if (pop)                   state_d = ISSUE;
        else if (head_is_load)          state_d = WAIT_MEM;
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  // Counts consecutive WAIT_MEM cycles spent on the same head without data.
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_MEM && state_d == WAIT_MEM && !mem_rvalid) tmo_d = tmo_q + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      wr_sel_q  <= WR_NONE;
      wr_data_q <= '0;
      err_q     <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
`ifdef WB_LOAD_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign writeReg  = wr_sel_q;
  assign writeData = wr_data_q;
  assign err       = err_q;
  assign stall     = full | head_is_load;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized + directed bench for writeback_unit against a queue-based model.
module tb_writeback_unit;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [1:0]  res_sel = '0;
  logic        res_src = 1'b0;
  logic [31:0] res_data = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  writeReg;
  logic [31:0] writeData;
  logic        stall;
  logic [1:0]  err;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_sel(res_sel), .res_src(res_src), .res_data(res_data),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .writeReg(writeReg), .writeData(writeData), .stall(stall), .err(err)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        src;
    logic [31:0] d;
  } ent_t;

  // Reference model: in-order queue, head wait counter, output registers.
  ent_t        q[$];
  int          head_wait;
  logic [1:0]  m_sel;
  logic [31:0] m_data;
  logic [1:0]  m_err;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    head_wait = 0;
    m_sel  = 2'b00;
    m_data = '0;
    m_err  = 2'b00;
  endtask

  // One clock: drive inputs, check handshake outputs, advance model, check
  // registered outputs after the edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic src,
                      input logic [31:0] d, input logic rv, input logic [31:0] rd);
    bit ready;
    @(negedge clk);
    res_valid = v; res_sel = sel; res_src = src; res_data = d;
    mem_rvalid = rv; mem_rdata = rd;
    #1;
    ready = (q.size() < DEPTH);
    chk("res_ready", res_ready, ready);
    chk("stall", stall, (!ready) || (q.size() > 0 && q[0].src));

    m_sel = 2'b00;
    if (q.size() == 0) begin
      if (rv) m_err[0] = 1'b1;
    end else if (!q[0].src) begin
      if (rv) m_err[0] = 1'b1;
      m_sel = q[0].sel; m_data = q[0].d;
      void'(q.pop_front()); head_wait = 0;
    end else if (rv) begin
      m_sel = q[0].sel; m_data = rd;
      void'(q.pop_front()); head_wait = 0;
    end else begin
      head_wait++;
`ifdef WB_LOAD_TIMEOUT_EN
      // One ISSUE cycle plus TIMEOUT cycles in WAIT_MEM.
      if (head_wait == TIMEOUT + 1) begin
        m_err[1] = 1'b1;
        void'(q.pop_front()); head_wait = 0;
      end
`endif
    end
    if (v && ready) q.push_back('{sel: sel, src: src, d: d});

    @(posedge clk);
    #1;
    chk("writeReg", writeReg, m_sel);
    chk("writeData", writeData, m_data);
    chk("err", err, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    res_valid = 1'b0; mem_rvalid = 1'b0;
    #1;
    model_clear();
    chk("rst_writeReg", writeReg, 2'b00);
    chk("rst_writeData", writeData, 32'h0);
    chk("rst_err", err, 2'b00);
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    #3;
    chk("por_writeReg", writeReg, 2'b00);
    chk("por_writeData", writeData, 32'h0);
    chk("por_err", err, 2'b00);
    chk("por_res_ready", res_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ALU result to reg1Addr: write one cycle after acceptance.
    step(1'b1, 2'b10, 1'b0, 32'h0000_00AA, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alu_sel", writeReg, 2'b10);
    chk("alu_data", writeData, 32'hAA);

    // Load to reg2Addr then ALU to r31: strict ordering behind the load.
    step(1'b1, 2'b11, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(1'b1, 2'b01, 1'b0, 32'h5, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h1234);
    chk("ld_sel", writeReg, 2'b11);
    chk("ld_data", writeData, 32'h1234);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("ord_sel", writeReg, 2'b01);
    chk("ord_data", writeData, 32'h5);

    // Back-to-back pushes behind a stuck load fill the queue.
    step(1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b1, 2'b01, 1'b0, 32'h11, 1'b0, 32'h0);
    #1;
    chk("full_ready", res_ready, 1'b0);
    chk("full_stall", stall, 1'b1);
    step(1'b1, 2'b11, 1'b0, 32'h22, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h77);
    idle(3);

    // Load with sel=00 consumes its data; stray data afterwards is spurious.
    step(1'b1, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h99);
    chk("none_sel", writeReg, 2'b00);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h55);
    chk("spur_err", err, 2'b01);
    chk("spur_sel", writeReg, 2'b00);

    async_reset();

    // Load head with no data: waits (or times out when enabled).
    step(1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 32'h0);
    idle(TIMEOUT + 3);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'hABCD);
    idle(2);

    // Reset during WAIT_MEM with two entries queued.
    async_reset();
    step(1'b1, 2'b11, 1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    async_reset();
    idle(3);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h4444);
    chk("post_rst_sel", writeReg, 2'b00);
    chk("post_rst_err0", err[0], 1'b1);

    async_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
           $urandom, $urandom_range(0, 3) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2: writeback queue entries, power of two, 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles allowed for load data, 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port res_valid  input  1  execute stage offers a result.
REQ-006 SHALL have port res_ready  output  1  queue accepts result; equals !full.
REQ-007 SHALL have port res_sel  input  2  target code: 00 none, 01 r31, 10 reg1Addr, 11 reg2Addr.
REQ-008 SHALL have port res_src  input  1  0 = ALU data in res_data; 1 = load, data arrives on mem_rdata.
REQ-009 SHALL have port res_data  input  32  ALU result; ignored when res_src=1.
REQ-010 SHALL have port mem_rvalid  input  1  load data strobe from data memory.
REQ-011 SHALL have port mem_rdata  input  32  load data, qualified by mem_rvalid.
REQ-012 SHALL have port writeReg  output  2  register-file write code, registered, same encoding as res_sel.
REQ-013 SHALL have port writeData  output  32  register-file write data, registered.
REQ-014 SHALL have port stall  output  1  high while full or head waits for load data.
REQ-015 SHALL have port err  output  2  sticky flags: bit0 spurious mem_rvalid, bit1 load timeout.

Function
REQ-016 SHALL accept an entry {sel, src, data} on a cycle with res_valid && res_ready; no pass-through.
REQ-017 SHALL retire entries strictly in acceptance order, one per cycle maximum.
REQ-018 SHALL use FSM states EMPTY, ISSUE, WAIT_MEM; EMPTY->ISSUE on push; ISSUE->WAIT_MEM when head src=1; ISSUE/WAIT_MEM->EMPTY on pop leaving count 0.
REQ-019 SHALL, for an ALU head, pop it and drive writeReg=sel, writeData=data on the following cycle (acceptance cycle N -> write visible N+1 at earliest).
REQ-020 SHALL, for a load head, wait in WAIT_MEM; on mem_rvalid in cycle M pop and drive writeReg=sel, writeData=mem_rdata in cycle M+1.
REQ-021 SHALL pop sel=00 entries with writeReg=00 (a load with sel=00 still consumes its mem_rvalid).
REQ-022 SHALL drive writeReg=00 and hold writeData unchanged on every cycle without a retirement.
REQ-023 SHALL, on mem_rvalid while EMPTY or head is ALU, ignore the data and set err[0].
REQ-024 SHALL handle push and pop in the same cycle, count unchanged; push into full queue is impossible (res_ready low).
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count is clog2(DEPTH)+1 bits.

Reset
REQ-026 SHALL on rst low immediately clear writeReg=00, writeData=0, count=0, pointers=0, state=EMPTY, err=00, timeout counter=0.
REQ-027 SHALL discard queued entries and pending loads on reset mid-operation; mem_rvalid after release sets err[0].
REQ-028 SHALL hold res_ready=0 while rst is low, 1 after release.

Configuration
REQ-029 SHALL implement timeout only when macro WB_LOAD_TIMEOUT_EN is defined: after TIMEOUT consecutive WAIT_MEM cycles without mem_rvalid, pop head with writeReg=00 and set err[1].
REQ-030 SHALL, without WB_LOAD_TIMEOUT_EN, wait indefinitely in WAIT_MEM and tie err[1] to 0.

Structure
REQ-031 SHALL take write-target codes (WR_NONE, WR_RA, WR_REG1, WR_REG2), the source enum and the FSM state typedef from shared package kgp_risc_pkg.
REQ-032 SHALL instantiate one sub-module wb_fifo (storage, pointers, count, full/empty); FSM and timeout live in writeback_unit.

Verification
REQ-033 SHALL cover: push ALU {10, 0x0000_00AA} cycle 5 -> writeReg=10, writeData=0xAA cycle 6.
REQ-034 SHALL cover: push load {11} then ALU {01, 0x5}; mem_rvalid=1, rdata=0x1234 cycle 10 -> cycle 11 writes 11/0x1234, cycle 12 writes 01/0x5.
REQ-035 SHALL cover: DEPTH=2, three back-to-back pushes with load head, no rvalid -> res_ready=0, stall=1 after second push.
REQ-036 SHALL cover: mem_rvalid while empty -> err=01, writeReg stays 00.
REQ-037 SHALL cover: WB_LOAD_TIMEOUT_EN, TIMEOUT=4, load head without rvalid -> popped after 4 cycles, err[1]=1, no write.
REQ-038 SHALL cover: rst low during WAIT_MEM with 2 entries -> all outputs zero at once, count=0, no later writes.
